// File: rtl/seq_stage_ctrl.sv
// ============================================================================
// seq_stage_ctrl : phase sequencer, PC owner and status tracker for Y86-64 SEQ
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_stage_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic [3:0]       icode,
  input  logic             imem_error,
  input  logic             instr_valid,
  input  logic             mem_ready,
  input  logic             dmem_error,
  input  logic [63:0]      PC_new,
  output logic [63:0]      PC,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic [2:0]       Stat,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  state_t           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic             mem_use;

  // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq
  always_comb begin
    case (icode)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: mem_use = 1'b1;
      default:                            mem_use = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    stat_d    = stat_q;
    icnt_d    = icnt_q;
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    mem_en    = 1'b0;
    wb_en     = 1'b0;
    pc_en     = 1'b0;
    busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    halted    = (state_q == S_HALT);
    cyc_d     = busy ? cyc_q + CNT_W'(1) : cyc_q;

    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        fetch_en = 1'b1;
        if (imem_error) begin
          state_d = S_HALT;
          stat_d  = STAT_ADR;
        end else if (!instr_valid) begin
          state_d = S_HALT;
          stat_d  = STAT_INS;
        end else if (icode == 4'h0) begin
          state_d = S_HALT;
          stat_d  = STAT_HLT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        decode_en = 1'b1;
        state_d   = S_EXECUTE;
      end
      S_EXECUTE: begin
        exec_en = 1'b1;
        state_d = S_MEMORY;
      end
      S_MEMORY: begin
        if (!mem_use) begin
          state_d = S_WRITEBACK;
        end else begin
          mem_en = 1'b1;
          if (mem_ready) begin
            if (dmem_error) begin
              state_d = S_HALT;
              stat_d  = STAT_ADR;
            end else begin
              state_d = S_WRITEBACK;
            end
          end
        end
      end
      S_WRITEBACK: begin
        wb_en   = 1'b1;
        state_d = S_PCUPD;
      end
      S_PCUPD: begin
        pc_en   = 1'b1;
        pc_d    = PC_new;
        icnt_d  = icnt_q + CNT_W'(1);
        state_d = run ? S_FETCH : S_IDLE;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      cyc_q   <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      cyc_q   <= cyc_d;
      icnt_q  <= icnt_d;
    end
  end

  assign PC          = pc_q;
  assign Stat        = stat_q;
  assign cycle_count = cyc_q;
  assign instr_count = icnt_q;

endmodule

`default_nettype wire
